// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry decode/execute pipeline register with operand
// forwarding, operand selection and ALU control fix-up at capture time.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_pc,
   input  logic [63:0] in_rs1_data,
   input  logic [63:0] in_rs2_data,
   input  logic [63:0] in_imm,
   input  logic [4:0]  in_rs1_addr,
   input  logic [4:0]  in_rs2_addr,
   input  logic [4:0]  in_rd_addr,
   input  logic [3:0]  in_alu_funct,
   input  logic        in_src_a_pc,
   input  logic        in_src_b_imm,
   input  logic        in_is_word,
   input  logic        in_reg_write,
   input  logic        fwd_mem_valid,
   input  logic [4:0]  fwd_mem_rd,
   input  logic [63:0] fwd_mem_data,
   input  logic        fwd_wb_valid,
   input  logic [4:0]  fwd_wb_rd,
   input  logic [63:0] fwd_wb_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] operand_a,
   output logic [63:0] operand_b,
   output logic [3:0]  alu_funct,
   output logic        is_word,
   output logic [4:0]  rd_addr,
   output logic        reg_write,
   output logic [63:0] pc
);
   logic        valid_q, valid_d;
   logic [63:0] opa_q, opa_d, opb_q, opb_d, pc_q, pc_d;
   logic [3:0]  funct_q, funct_d;
   logic        word_q, word_d, rw_q, rw_d;
   logic [4:0]  rd_q, rd_d;
   logic        capture;
   logic [63:0] rs1_fwd, rs2_fwd, opb_raw;
   logic        shift_w;

   assign in_ready  = rst || !valid_q || out_ready;
   assign capture   = in_valid && in_ready && !flush;
   assign out_valid = valid_q;
   assign operand_a = opa_q;
   assign operand_b = opb_q;
   assign alu_funct = funct_q;
   assign is_word   = word_q;
   assign rd_addr   = rd_q;
   assign reg_write = rw_q;
   assign pc        = pc_q;

   always_comb begin
      rs1_fwd = (fwd_mem_valid && fwd_mem_rd == in_rs1_addr && in_rs1_addr != 5'd0) ? fwd_mem_data :
                (fwd_wb_valid && fwd_wb_rd == in_rs1_addr && in_rs1_addr != 5'd0) ? fwd_wb_data : in_rs1_data;
      rs2_fwd = (fwd_mem_valid && fwd_mem_rd == in_rs2_addr && in_rs2_addr != 5'd0) ? fwd_mem_data :
                (fwd_wb_valid && fwd_wb_rd == in_rs2_addr && in_rs2_addr != 5'd0) ? fwd_wb_data : in_rs2_data;
      opb_raw = in_src_b_imm ? in_imm : rs2_fwd;
      // 32-bit shifts only honour a 5-bit shift amount
      shift_w = in_is_word && (in_alu_funct[2:0] == 3'b001 || in_alu_funct[2:0] == 3'b101);
      valid_d = flush ? 1'b0 : capture ? 1'b1 : out_ready ? 1'b0 : valid_q;
      opa_d   = capture ? (in_src_a_pc ? in_pc : rs1_fwd) : opa_q;
      opb_d   = capture ? (shift_w ? {59'd0, opb_raw[4:0]} : opb_raw) : opb_q;
      // bit 3 selects SUB/SRA; for immediates only the shift-right form keeps it
      funct_d = capture ? {(!in_src_b_imm || in_alu_funct[2:0] == 3'b101) && in_alu_funct[3], in_alu_funct[2:0]} : funct_q;
      word_d  = capture ? in_is_word : word_q;
      rd_d    = capture ? in_rd_addr : rd_q;
      rw_d    = capture ? (in_reg_write && in_rd_addr != 5'd0) : rw_q;
      pc_d    = capture ? in_pc : pc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         funct_q <= '0;
         word_q  <= 1'b0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         funct_q <= funct_d;
         word_q  <= word_d;
         rd_q    <= rd_d;
         rw_q    <= rw_d;
         pc_q    <= pc_d;
      end
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: in_valid input 1, in_ready output 1 (upstream decode handshake).
REQ-004 SHALL have ports: in_pc 64, in_rs1_data 64, in_rs2_data 64, in_imm 64 (all inputs; regfile reads and sign-extended immediate).
REQ-005 SHALL have ports: in_rs1_addr 5, in_rs2_addr 5, in_rd_addr 5, in_alu_funct 4, in_src_a_pc 1, in_src_b_imm 1, in_is_word 1, in_reg_write 1 (all inputs).
REQ-006 SHALL have forwarding inputs: fwd_mem_valid 1, fwd_mem_rd 5, fwd_mem_data 64, fwd_wb_valid 1, fwd_wb_rd 5, fwd_wb_data 64.
REQ-007 SHALL have port: flush  input  1  kill held and incoming instruction.
REQ-008 SHALL have ports: out_valid output 1, out_ready input 1 (downstream execute handshake).
REQ-009 SHALL have outputs: operand_a 64, operand_b 64, alu_funct 4, is_word 1, rd_addr 5, reg_write 1, pc 64; all registered.

Function
REQ-010 SHALL hold one instruction; state FULL = out_valid.
REQ-011 SHALL drive in_ready = !out_valid || out_ready (combinational, pass-through on same-cycle drain).
REQ-012 SHALL capture inputs on edge when in_valid && in_ready && !flush; out_valid becomes 1 next cycle.
REQ-013 SHALL clear out_valid when out_ready && out_valid and no capture occurs that cycle.
REQ-014 SHALL hold all outputs stable while out_valid && !out_ready (stall); no capture.
REQ-015 SHALL, on flush, clear out_valid next edge, discarding held and same-cycle incoming instruction; flush wins over capture.
REQ-016 SHALL resolve rs1/rs2 at capture with priority: MEM match, then WB match, then regfile data.
REQ-017 SHALL treat a match as fwd_*_valid && fwd_*_rd == rsN_addr && rsN_addr != 0; x0 never forwarded, reads as regfile value.
REQ-018 SHALL set operand_a = in_src_a_pc ? in_pc : forwarded rs1.
REQ-019 SHALL set operand_b = in_src_b_imm ? in_imm : forwarded rs2.
REQ-020 SHALL, when in_is_word and in_alu_funct[2:0] is 3'b001 (SLL) or 3'b101 (SHIFTR), zero operand_b[63:5] so shift amount is 5 bits.
REQ-021 SHALL pass alu_funct[2:0] unchanged; alu_funct[3] = in_alu_funct[3] only when !in_src_b_imm or in_alu_funct[2:0]==3'b101, else 0 (ADDI never becomes SUB).
REQ-022 SHALL force reg_write output 0 when in_rd_addr == 0.
REQ-023 SHALL not re-sample forwarding inputs after capture; stalled operands keep captured values.

Reset
REQ-024 SHALL, on rst assertion, immediately clear out_valid and zero operand_a, operand_b, alu_funct, is_word, rd_addr, reg_write, pc regardless of clk.
REQ-025 SHALL, during rst, drive in_ready = 1 and discard in_valid; first capture on first edge after rst deasserts.
REQ-026 SHALL abandon a stalled instruction when rst asserts mid-stall; no output after release until new capture.

Verification
REQ-027 Basic ADD: rs1_data=5, rs2_data=7, funct=0000, no fwd, out_ready=1 -> next cycle out_valid=1, operand_a=5, operand_b=7, alu_funct=0000.
REQ-028 Forward priority: rs1_addr=3, MEM rd=3 data=0xAA, WB rd=3 data=0xBB, regfile 0x11 -> operand_a=0xAA; MEM invalid -> 0xBB; rs1_addr=0 with both matching rd=0 -> regfile value.
REQ-029 Stall/drain: capture A, hold out_ready=0 three cycles while in_valid=1 with B -> in_ready=0, outputs stay A; out_ready=1 -> B captured same edge A drains, out_valid stays 1.
REQ-030 Flush: held A and incoming B with flush=1 -> next cycle out_valid=0, B not captured; no output until new in_valid.
REQ-031 Word shift/imm: in_is_word=1, funct=1101, src_b_imm=1, imm=0x..FFE5 -> operand_b=0x05, alu_funct=1101; ADDI funct=1000 src_b_imm=1 -> alu_funct=0000.
REQ-032 Async reset mid-stall: rst pulsed between edges while out_valid=1 -> out_valid and all outputs 0 before next edge; rd_addr=0 capture -> reg_write=0.
